i2c_cmd_queue: RTL and testbench



---
 rtl/i2c_cmd_queue.sv | 115 +++++++++++
 tb/tb_i2c_cmd_queue.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: FIFO-buffered single-byte I2C command sequencer driving an I2C master's enable/ready handshake
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             upstream push handshake; cmd_addr/cmd_rw/cmd_data form one command
//   m_addr/m_data_in/m_rw/m_enable  launch interface to the master, fields change only on pop edges
//   m_ready/m_data_out              master idle flag and read result
//   rsp_valid/rsp_data              one-cycle read-completion strobe, rsp_data held until the next read
//   err_timeout                     one-cycle strobe: master never went busy after a launch
//   level, busy                     FIFO occupancy and sequencer-not-idle
module i2c_cmd_queue #(
    parameter int DEPTH     = 4,
    parameter int EN_CYCLES = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_addr,
    input  logic                   cmd_rw,
    input  logic [7:0]             cmd_data,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_rw,
    output logic                   m_enable,
    input  logic                   m_ready,
    input  logic [7:0]             m_data_out,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = DEPTH[LW-1:0];
    localparam logic [15:0] EN_LAST = 16'(EN_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_d;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   cnt, cnt_d;
    logic          seen_busy, seen_d, push, pop, rsp_d, err_d;

    assign cmd_ready = level != FULL;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = state != IDLE;
    // Decoded from state so reset drops it without waiting for a clock edge.
    assign m_enable  = state == LAUNCH;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        seen_d  = seen_busy;
        pop     = 1'b0;
        rsp_d   = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: if (level != '0 && m_ready) begin
                pop     = 1'b1;
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                // A master that goes busy while enable is still high skips WAIT_BUSY.
                seen_d = seen_busy | ~m_ready;
                cnt_d  = cnt == EN_LAST ? '0 : cnt + 16'd1;
                if (cnt == EN_LAST) state_d = seen_d ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: if (!m_ready) state_d = WAIT_DONE;
            else if (cnt == TO_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else cnt_d = cnt + 16'd1;
            WAIT_DONE: if (m_ready) begin
                rsp_d   = m_rw;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            seen_busy   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
            m_rw        <= 1'b0;
            m_addr      <= '0;
            m_data_in   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            seen_busy   <= seen_d;
            rsp_valid   <= rsp_d;
            err_timeout <= err_d;
            if (rsp_d) rsp_data <= m_data_out;
            if (pop) {m_rw, m_addr, m_data_in} <= mem[rd_ptr];
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb_i2c_cmd_queue: randomized self-checking bench for i2c_cmd_queue with an I2C master model and command-order scoreboard
module tb_i2c_cmd_queue;
    localparam int DEPTH = 4, EN_CYCLES = 5, TIMEOUT = 255;

    logic       clk = 1'b0, rst_n, cmd_valid, cmd_ready, cmd_rw, m_rw, m_enable, m_ready;
    logic       rsp_valid, err_timeout, busy;
    logic [6:0] cmd_addr, m_addr;
    logic [7:0] cmd_data, m_data_in, m_data_out, rsp_data;
    logic [2:0] level;

    always #5 clk = ~clk;

    i2c_cmd_queue #(.DEPTH(DEPTH), .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
        .m_ready(m_ready), .m_data_out(m_data_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .err_timeout(err_timeout), .level(level), .busy(busy)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;
    // Scoreboard: commands accepted, in order, and read bytes the master handed back.
    logic [15:0] exp_q[$], launches[$];
    logic [7:0]  exp_rsp[$], rsps[$];
    int          en_lens[$], launch_cyc[$], err_cyc[$];
    int          stab_bad, strobe_bad, hold_bad, en_cnt;
    logic        prev_en, prev_rv, prev_err;
    logic [15:0] prev_out;
    logic [7:0]  prev_rd;
    // Master model: mode 0 normal, 1 never goes busy, 2 holds ready low, 3 goes busy forever on launch.
    int          mst_mode = 0, mst_phase = 0, mst_dly, mst_bsy;
    logic        mst_rw, mst_fix = 1'b0;
    logic [7:0]  mst_fix_val;

    task automatic sync_prev();
        prev_en  = m_enable;
        prev_out = {m_rw, m_addr, m_data_in};
        prev_rv  = rsp_valid;
        prev_err = err_timeout;
        prev_rd  = rsp_data;
    endtask

    task automatic clear_obs();
        exp_q.delete(); launches.delete(); exp_rsp.delete(); rsps.delete();
        en_lens.delete(); launch_cyc.delete(); err_cyc.delete();
        stab_bad = 0; strobe_bad = 0; hold_bad = 0; en_cnt = 0;
        sync_prev();
    endtask

    task automatic cycle();
        logic [7:0] b;
        @(posedge clk);
        #1;
        cyc++;
        if (m_enable && !prev_en) begin
            launches.push_back({m_rw, m_addr, m_data_in});
            launch_cyc.push_back(cyc);
            en_cnt = 0;
        end
        if (m_enable) en_cnt++;
        if (!m_enable && prev_en) en_lens.push_back(en_cnt);
        if ({m_rw, m_addr, m_data_in} != prev_out && !(m_enable && !prev_en)) stab_bad++;
        if (rsp_valid) rsps.push_back(rsp_data);
        if (rsp_valid && prev_rv) strobe_bad++;
        if (err_timeout && prev_err) strobe_bad++;
        if (err_timeout) err_cyc.push_back(cyc);
        if (!rsp_valid && rsp_data != prev_rd) hold_bad++;
        sync_prev();
        if (mst_mode == 1) m_ready = 1'b1;
        else if (mst_mode == 2) m_ready = 1'b0;
        else if (mst_mode == 3) begin
            if (m_enable) m_ready = 1'b0;
        end else begin
            if (mst_phase == 0) begin
                m_ready = 1'b1;
                if (m_enable) begin
                    mst_rw    = m_rw;
                    mst_dly   = $urandom_range(0, EN_CYCLES + 3);
                    mst_phase = 1;
                end
            end
            if (mst_phase == 1) begin
                if (mst_dly == 0) begin
                    m_ready   = 1'b0;
                    mst_bsy   = $urandom_range(1, 5);
                    mst_phase = 2;
                end else mst_dly--;
            end else if (mst_phase == 2) begin
                mst_bsy--;
                if (mst_bsy == 0) begin
                    b          = mst_fix ? mst_fix_val : 8'($urandom);
                    m_ready    = 1'b1;
                    m_data_out = b;
                    if (mst_rw) exp_rsp.push_back(b);
                    mst_phase = 3;
                end
            end else if (mst_phase == 3 && !m_enable) mst_phase = 0;
        end
    endtask

    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d, output bit ok, output int acc_cyc);
        bit acc;
        ok = 0;
        acc_cyc = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_data = d;
        for (int i = 0; i < 2000 && !ok; i++) begin
            acc = cmd_ready;
            cycle();
            if (acc) begin
                ok = 1;
                acc_cyc = cyc;
                exp_q.push_back({rw, a, d});
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            cycle();
            if (level == 0 && !busy && (mst_phase == 0 || mst_phase == 3)) ok = 1;
        end
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({m_enable, m_addr, m_data_in, m_rw, rsp_valid, rsp_data, err_timeout, level, busy, cmd_ready}
            !== {1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got en=%b addr=%h din=%h rw=%b rv=%b rd=%h err=%b lvl=%0d busy=%b rdy=%b, expected all 0 with cmd_ready=1",
                     m_enable, m_addr, m_data_in, m_rw, rsp_valid, rsp_data, err_timeout, level, busy, cmd_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
        repeat (3) cycle();
        n_checks++;
        if ({m_enable, busy, level, cmd_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got en=%b busy=%b lvl=%0d rdy=%b, expected 0 0 0 1", m_enable, busy, level, cmd_ready);
        end
    endtask

    task automatic test_single_write();
        bit ok;
        int ac;
        clear_obs();
        mst_mode = 0;
        push(7'h2A, 1'b0, 8'h06, ok, ac);
        n_checks++;
        if ({ok, level, m_enable} !== {1'b1, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL write_accept: got ok=%b lvl=%0d en=%b, expected 1 1 0", ok, level, m_enable);
        end
        cycle();
        n_checks++;
        if ({m_enable, level, m_data_in} !== {1'b1, 3'd0, 8'h06}) begin
            n_fail++;
            $display("FAIL write_pop_edge: got en=%b lvl=%0d din=%h, expected 1 0 06", m_enable, level, m_data_in);
        end
        drain(ok);
        n_checks++;
        if (!ok || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: got drained=%b busy=%b, expected 1 0", ok, busy);
        end
        n_checks++;
        if (launches.size() != 1 || launches[0] !== {1'b0, 7'h2A, 8'h06} || launch_cyc[0] != ac + 1) begin
            n_fail++;
            $display("FAIL write_launch: got %0d launches first=%h at cycle %0d, expected 1 launch 2a06 at cycle %0d",
                     launches.size(), launches.size() ? launches[0] : 16'h0, launch_cyc.size() ? launch_cyc[0] : -1, ac + 1);
        end
        n_checks++;
        if (en_lens.size() != 1 || en_lens[0] != EN_CYCLES) begin
            n_fail++;
            $display("FAIL write_en_len: got %0d pulses len %0d, expected 1 pulse len %0d", en_lens.size(), en_lens.size() ? en_lens[0] : -1, EN_CYCLES);
        end
        n_checks++;
        if (rsps.size() != 0 || stab_bad != 0) begin
            n_fail++;
            $display("FAIL write_no_rsp: got %0d rsp strobes, %0d field changes off pop, expected 0 0", rsps.size(), stab_bad);
        end
    endtask

    task automatic test_read();
        bit ok;
        int ac;
        clear_obs();
        mst_fix = 1'b1;
        mst_fix_val = 8'hA5;
        push(7'h2A, 1'b1, 8'($urandom), ok, ac);
        drain(ok);
        mst_fix = 1'b0;
        n_checks++;
        if (!ok || rsps.size() != 1 || rsps[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_rsp: got drained=%b %0d strobes first=%h, expected 1 strobe a5", ok, rsps.size(), rsps.size() ? rsps[0] : 8'h0);
        end
        n_checks++;
        if (rsp_data !== 8'hA5 || strobe_bad != 0 || hold_bad != 0) begin
            n_fail++;
            $display("FAIL read_hold: got rsp_data=%h long_strobes=%0d unheld=%0d, expected a5 0 0", rsp_data, strobe_bad, hold_bad);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int ac;
        logic [6:0] a5;
        clear_obs();
        mst_mode = 2;
        cycle();
        for (int i = 1; i <= 4; i++) push(7'($urandom), 1'b0, 8'(i), ok, ac);
        n_checks++;
        if ({level, cmd_ready, m_enable} !== {3'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_full: got lvl=%0d rdy=%b en=%b, expected 4 0 0", level, cmd_ready, m_enable);
        end
        a5 = 7'($urandom);
        cmd_valid = 1'b1; cmd_addr = a5; cmd_rw = 1'b0; cmd_data = 8'd5;
        repeat (3) cycle();
        n_checks++;
        if ({level, cmd_ready, busy} !== {3'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_backpressure: got lvl=%0d rdy=%b busy=%b, expected 4 0 0", level, cmd_ready, busy);
        end
        mst_mode = 0;
        push(a5, 1'b0, 8'd5, ok, ac);
        drain(ok);
        n_checks++;
        if (!ok || launches.size() != 5 || exp_q.size() != 5) begin
            n_fail++;
            $display("FAIL fill_count: got drained=%b %0d launches %0d accepted, expected 5 5", ok, launches.size(), exp_q.size());
        end
        for (int i = 0; i < 5 && i < launches.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (launches[i] !== exp_q[i] || launches[i][7:0] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got %h, expected %h with data %0d", i, launches[i], exp_q[i], i + 1);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok, got;
        int ac;
        logic rw_b;
        clear_obs();
        mst_mode = 1;
        rw_b = 1'($urandom);
        push(7'($urandom), 1'($urandom), 8'($urandom), ok, ac);
        push(7'($urandom), rw_b, 8'($urandom), ok, ac);
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            cycle();
            if (err_timeout) got = 1;
        end
        mst_mode = 0;
        n_checks++;
        if (!got || err_cyc.size() != 1 || launch_cyc.size() < 1 || err_cyc[0] - launch_cyc[0] != EN_CYCLES + TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_delay: got seen=%b delay=%0d, expected 1 %0d", got,
                     (err_cyc.size() && launch_cyc.size()) ? err_cyc[0] - launch_cyc[0] : -1, EN_CYCLES + TIMEOUT);
        end
        cycle();
        n_checks++;
        if (err_timeout !== 1'b0 || m_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next: got err=%b en=%b, expected 0 1", err_timeout, m_enable);
        end
        drain(ok);
        n_checks++;
        if (!ok || launches.size() != 2 || launches[0] !== exp_q[0] || launches[1] !== exp_q[1] || err_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_order: got drained=%b %0d launches %0d errors, expected 2 launches in order and 1 error",
                     ok, launches.size(), err_cyc.size());
        end
        n_checks++;
        if (rsps.size() != exp_rsp.size() || rsps.size() != int'(rw_b) || strobe_bad != 0) begin
            n_fail++;
            $display("FAIL timeout_rsp: got %0d strobes (%0d long), expected %0d", rsps.size(), strobe_bad, int'(rw_b));
        end
    endtask

    task automatic test_simul();
        bit ok, acc;
        int ac;
        logic [15:0] c3;
        clear_obs();
        mst_mode = 2;
        cycle();
        push(7'($urandom), 1'($urandom), 8'($urandom), ok, ac);
        push(7'($urandom), 1'($urandom), 8'($urandom), ok, ac);
        c3 = 16'($urandom);
        cmd_valid = 1'b1; {cmd_rw, cmd_addr, cmd_data} = c3;
        m_ready = 1'b1;
        mst_mode = 0;
        acc = cmd_ready;
        cycle();
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back(c3);
        n_checks++;
        if ({acc, level, m_enable} !== {1'b1, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_level: got acc=%b lvl=%0d en=%b, expected 1 2 1", acc, level, m_enable);
        end
        drain(ok);
        n_checks++;
        if (!ok || launches.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL simul_count: got drained=%b %0d launches, expected 3", ok, launches.size());
        end
        for (int i = 0; i < launches.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (launches[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL simul_order[%0d]: got %h, expected %h", i, launches[i], exp_q[i]);
            end
        end
        n_checks++;
        if (rsps.size() != exp_rsp.size()) begin
            n_fail++;
            $display("FAIL simul_rsp: got %0d strobes, expected %0d", rsps.size(), exp_rsp.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        int ac;
        clear_obs();
        mst_mode = 3;
        for (int i = 0; i < 4; i++) push(7'($urandom), 1'($urandom), 8'($urandom), ok, ac);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle();
            if (busy && !m_enable && level == 3) hit = 1;
        end
        repeat (2) cycle();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hit, m_enable, level, cmd_ready, busy, rsp_valid, err_timeout} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got waiting=%b en=%b lvl=%0d rdy=%b busy=%b rv=%b err=%b, expected 1 0 0 1 0 0 0",
                     hit, m_enable, level, cmd_ready, busy, rsp_valid, err_timeout);
        end
        mst_mode = 0; mst_phase = 0; m_ready = 1'b1;
        clear_obs();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        n_checks++;
        if (rsps.size() != 0 || err_cyc.size() != 0 || launches.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d rsp %0d err %0d launches, expected 0 0 0", rsps.size(), err_cyc.size(), launches.size());
        end
        mst_fix = 1'b1;
        mst_fix_val = 8'($urandom);
        push(7'h11, 1'b1, 8'h00, ok, ac);
        drain(ok);
        mst_fix = 1'b0;
        n_checks++;
        if (!ok || launches.size() != 1 || launches[0] !== {1'b1, 7'h11, 8'h00} || rsps.size() != 1 || rsps[0] !== mst_fix_val) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got %0d launches %0d rsps first=%h, expected 1 1 %h",
                     launches.size(), rsps.size(), rsps.size() ? rsps[0] : 8'h0, mst_fix_val);
        end
    endtask

    task automatic test_random();
        bit ok;
        int ac, bad_len;
        clear_obs();
        mst_mode = 0;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) cycle();
            push(7'($urandom), 1'($urandom), 8'($urandom), ok, ac);
        end
        drain(ok);
        n_checks++;
        if (!ok || launches.size() != exp_q.size() || exp_q.size() != 30) begin
            n_fail++;
            $display("FAIL rand_count: got drained=%b %0d launches %0d accepted, expected 30 30", ok, launches.size(), exp_q.size());
        end
        for (int i = 0; i < launches.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (launches[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_order[%0d]: got %h, expected %h", i, launches[i], exp_q[i]);
            end
        end
        n_checks++;
        if (rsps.size() != exp_rsp.size()) begin
            n_fail++;
            $display("FAIL rand_rsp_count: got %0d, expected %0d", rsps.size(), exp_rsp.size());
        end
        for (int i = 0; i < rsps.size() && i < exp_rsp.size(); i++) begin
            n_checks++;
            if (rsps[i] !== exp_rsp[i]) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %h, expected %h", i, rsps[i], exp_rsp[i]);
            end
        end
        bad_len = 0;
        foreach (en_lens[i]) if (en_lens[i] != EN_CYCLES) bad_len++;
        n_checks++;
        if (bad_len != 0 || err_cyc.size() != 0 || stab_bad != 0 || strobe_bad != 0 || hold_bad != 0) begin
            n_fail++;
            $display("FAIL rand_protocol: got bad_en=%0d errs=%0d field_chg=%0d long_strobes=%0d unheld=%0d, expected all 0",
                     bad_len, err_cyc.size(), stab_bad, strobe_bad, hold_bad);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_data = '0;
        m_ready = 1'b1; m_data_out = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_read();
        test_fill();
        test_timeout();
        test_simul();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
